// File: rtl/fht_pkg.sv
// Shared FHT definitions: sequencer state encoding and the (stage, butterfly)
// to twiddle-address / operand-index mapping used by the agen and memory control.
package fht_pkg;

  localparam int P_BIT_DEF = 7;
  localparam int POINTS    = 1 << P_BIT_DEF;
  localparam int HALF      = POINTS / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
`ifdef FHT_AGEN_STAGE_GAP_EN
    , ST_GAP = 2'd3
`endif
  } agen_state_t;

  // Offset of butterfly b inside its group at stage s.
  function automatic logic [31:0] agen_k(input logic [31:0] s, input logic [31:0] b);
    return b & ((32'd1 << s) - 32'd1);
  endfunction

  // Half-period ROM: stage s steps the angle by POINTS/2^(s+1) table entries.
  function automatic logic [31:0] agen_addr(input logic [31:0] p_bit, input logic [31:0] s,
                                            input logic [31:0] b);
    return agen_k(s, b) << (p_bit - 32'd1 - s);
  endfunction

  function automatic logic [31:0] agen_idx_a(input logic [31:0] s, input logic [31:0] b);
    return ((b >> s) << (s + 32'd1)) + agen_k(s, b);
  endfunction

  function automatic logic [31:0] agen_idx_b(input logic [31:0] s, input logic [31:0] b);
    return agen_idx_a(s, b) + (32'd1 << s);
  endfunction

endpackage

// File: rtl/fht_twiddle_agen_if.sv
// Sequencer-side bundle of the twiddle address generator: start/ready controls
// plus the address, index, and status outputs.
interface fht_twiddle_agen_if
  import fht_pkg::*;
#(
  parameter int P_BIT = 7,
  parameter int A_BIT = P_BIT - 1,
  parameter int S_BIT = $clog2(P_BIT)
);
  // Handshake: a beat (oADDR, oIDX_A, oIDX_B, oSTAGE, oST_ZERO) transfers on
  // every clock edge where oVALID and iREADY are both high; while oVALID is
  // high and iREADY is low, every beat field stays stable until accepted.
  logic             iSTART;
  logic             iREADY;
  logic [A_BIT-1:0] oADDR;
  logic             oST_ZERO;
  logic [P_BIT-1:0] oIDX_A;
  logic [P_BIT-1:0] oIDX_B;
  logic [S_BIT-1:0] oSTAGE;
  logic             oVALID;
  logic             oTW_VALID;
  logic             oBUSY;
  logic             oDONE;
  agen_state_t      dbg_state;

  modport master (
    input  iSTART, iREADY,
    output oADDR, oST_ZERO, oIDX_A, oIDX_B, oSTAGE, oVALID, oTW_VALID, oBUSY, oDONE, dbg_state
  );

  modport slave (
    output iSTART, iREADY,
    input  oADDR, oST_ZERO, oIDX_A, oIDX_B, oSTAGE, oVALID, oTW_VALID, oBUSY, oDONE, dbg_state
  );
endinterface

// File: rtl/fht_agen_idx.sv
// Combinational mapper from (stage, butterfly) to twiddle ROM address and the
// butterfly operand index pair.
module fht_agen_idx
  import fht_pkg::*;
#(
  parameter int P_BIT = 7,
  parameter int A_BIT = P_BIT - 1,
  parameter int S_BIT = $clog2(P_BIT)
) (
  input  logic [S_BIT-1:0] s,
  input  logic [P_BIT-2:0] b,
  output logic [A_BIT-1:0] addr,
  output logic [P_BIT-1:0] idx_a,
  output logic [P_BIT-1:0] idx_b
);
  assign addr  = A_BIT'(agen_addr(32'(P_BIT), 32'(s), 32'(b)));
  assign idx_a = P_BIT'(agen_idx_a(32'(s), 32'(b)));
  assign idx_b = P_BIT'(agen_idx_b(32'(s), 32'(b)));
endmodule

// File: rtl/fht_twiddle_agen.sv
// Radix-2 FHT pass sequencer: walks all stages/butterflies after a start pulse.
// Optional FHT_AGEN_STAGE_GAP_EN inserts GAP_CYC idle cycles between stages.
module fht_twiddle_agen
  import fht_pkg::*;
#(
  parameter int P_BIT = P_BIT_DEF,
  parameter int A_BIT = P_BIT - 1,
  parameter int S_BIT = $clog2(P_BIT)
`ifdef FHT_AGEN_STAGE_GAP_EN
  , parameter int GAP_CYC = 4
`endif
) (
  input logic iCLK,
  input logic iRESET,
  fht_twiddle_agen_if.master bus
);
  localparam int B_W = P_BIT - 1;
  localparam logic [B_W-1:0]   B_LAST = {B_W{1'b1}};
  localparam logic [S_BIT-1:0] S_LAST = S_BIT'(P_BIT - 1);

  agen_state_t      state_q, state_d;
  logic [S_BIT-1:0] s_q, s_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             tw_valid_q;
  logic             run;
  logic [A_BIT-1:0] addr_w;
  logic [P_BIT-1:0] idx_a_w, idx_b_w;

`ifdef FHT_AGEN_STAGE_GAP_EN
  localparam int G_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [G_W-1:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
`ifdef FHT_AGEN_STAGE_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iSTART) begin
          s_d     = '0;
          b_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.iREADY) begin
          if (b_q == B_LAST) begin
            b_d = '0;
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
            end else begin
              s_d = s_q + 1'b1;
`ifdef FHT_AGEN_STAGE_GAP_EN
              state_d = ST_GAP;
              gap_d   = G_W'(GAP_CYC - 1);
`endif
            end
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
`ifdef FHT_AGEN_STAGE_GAP_EN
      // The gap is a fixed drain window, so it runs down regardless of iREADY.
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_RUN;
        else             gap_d   = gap_q - 1'b1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      b_q        <= '0;
      tw_valid_q <= 1'b0;
`ifdef FHT_AGEN_STAGE_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      b_q        <= b_d;
      tw_valid_q <= (state_q == ST_RUN);
`ifdef FHT_AGEN_STAGE_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  fht_agen_idx #(.P_BIT(P_BIT), .A_BIT(A_BIT), .S_BIT(S_BIT)) u_idx (
    .s     (s_q),
    .b     (b_q),
    .addr  (addr_w),
    .idx_a (idx_a_w),
    .idx_b (idx_b_w)
  );

  // Beat fields read as zero outside RUN so idle and reset look identical downstream.
  assign run           = (state_q == ST_RUN);
  assign bus.oADDR     = run ? addr_w  : '0;
  assign bus.oIDX_A    = run ? idx_a_w : '0;
  assign bus.oIDX_B    = run ? idx_b_w : '0;
  assign bus.oST_ZERO  = run & (s_q == '0);
  assign bus.oSTAGE    = s_q;
  assign bus.oVALID    = run;
  assign bus.oTW_VALID = tw_valid_q;
  assign bus.oBUSY     = (state_q != ST_IDLE);
  assign bus.oDONE     = (state_q == ST_DONE);
  assign bus.dbg_state = state_q;
endmodule

// File: doc/fht_twiddle_agen.md
# fht_twiddle_agen

Sequencer that drives a full radix-2 FHT pass. After a start pulse it walks every stage and every butterfly, producing the twiddle ROM address and stage-zero flag for the sin/cos ROM block. It also produces the butterfly operand indices for the data memory, with a valid flag delayed one cycle to line up with the ROM's registered output. It sits directly upstream of the twiddle ROM block and alongside the butterfly/memory controller.

## Interface
- `P_BIT`, default 7: log2 of transform length; `POINTS = 2^P_BIT`.
- `A_BIT`, default 6: ROM address width; fixed to `P_BIT-1`, so the ROM holds a half period, `angle(a) = 2*pi*a/POINTS`.
- `S_BIT`, default 3: stage counter width, `$clog2(P_BIT)`.
- `GAP_CYC`, default 4: idle cycles between stages; used only with `FHT_AGEN_STAGE_GAP_EN`.

Ports:
- `iCLK`  in  1  clock.
- `iRESET`  in  1  synchronous, active-high reset.
- `iSTART`  in  1  one-cycle start pulse; honoured only in IDLE.
- `iREADY`  in  1  downstream accepts; low freezes the sequencer.
- `oADDR`  out  A_BIT  twiddle ROM address.
- `oST_ZERO`  out  1  high while stage 0 is issued.
- `oIDX_A`  out  P_BIT  butterfly upper operand index.
- `oIDX_B`  out  P_BIT  butterfly lower operand index.
- `oSTAGE`  out  S_BIT  current stage.
- `oVALID`  out  1  address/index outputs valid this cycle.
- `oTW_VALID`  out  1  `oVALID` delayed one cycle; ROM output valid.
- `oBUSY`  out  1  high from the start pulse until `oDONE`.
- `oDONE`  out  1  one-cycle pulse after the last butterfly.

## Operation
- FSM states: IDLE, RUN, GAP (only with the macro), DONE.
- IDLE:
  - `iSTART` clears `s` and `b`, then goes to RUN.
  - In every other state `iSTART` is ignored.
- RUN:
  - Butterfly counter `b`, `0..POINTS/2-1`.
  - `k = b & (2^s-1)`, `g = b >> s`.
  - `oADDR = k << (P_BIT-1-s)`, truncated to A_BIT.
  - `oIDX_A = g*2^(s+1) + k`, `oIDX_B = oIDX_A + 2^s`.
  - `oST_ZERO = (s==0)`, `oVALID = 1`.
- Advance only when `oVALID & iREADY`.
- When `b` wraps:
  - Not the last stage: `s++` and `b=0`, then go to GAP (macro) or stay in RUN.
  - `s==P_BIT-1`: go to DONE.
- DONE: assert `oDONE` for one cycle, then IDLE; `oBUSY` falls with `oDONE`.
- `iREADY` low:
  - Hold `oADDR`, `oIDX_*`, `oVALID`, `oTW_VALID` and the counters.
  - Because the address is held, the ROM re-reads the same word, so its output stays stable.
- Reset, including mid-pass:
  - Next edge enters IDLE.
  - All outputs go to 0 (`oADDR`, `oIDX_*`, `oSTAGE`, `oST_ZERO`, `oVALID`, `oTW_VALID`, `oBUSY`, `oDONE`).
  - No `oDONE` is emitted for the aborted pass.
- Index arithmetic is unsigned at P_BIT width and never overflows by construction.

## Timing
- `iSTART` sampled at edge 0:
  - `oBUSY` and `oVALID` are high from cycle 1, carrying `s=0, b=0`.
  - `oTW_VALID` is high from cycle 2.
- With no stall and no gap, there are exactly `P_BIT*POINTS/2` consecutive `oVALID` cycles.
  - `oDONE` follows the final accepted beat by one cycle.
  - The final `oTW_VALID` coincides with `oDONE`.
- Outputs are registered; there is no combinational path from `iREADY` or `iSTART` to any output.

## Configuration
- `FHT_AGEN_STAGE_GAP_EN` defined:
  - Each stage boundary inserts GAP_CYC cycles with `oVALID=0`, giving butterfly write-back time to drain.
  - `oBUSY` stays high during the gap and `oSTAGE` already shows the new stage.
- Not defined:
  - The GAP state is not compiled.
  - Stages run back-to-back.

## Structure
- Shared package `fht_pkg`:
  - FSM state enum `agen_state_t`.
  - Function computing `k`, the ROM address and the index pair from `(s, b)`.
  - Constants `POINTS` and `HALF = POINTS/2`.
- One sub-module is natural, `fht_agen_idx`: a combinational index/address mapper driven by `(s, b)`, reused by the memory controller.
- Counters and FSM stay in the top module.

## Test plan
- P_BIT=3, `iREADY=1`, start pulse:
  - Stage 0: `oADDR` 0,0,0,0; `(A,B)` = (0,1)(2,3)(4,5)(6,7); `oST_ZERO=1`.
  - Stage 1: `oADDR` 0,2,0,2; `(A,B)` = (0,2)(1,3)(4,6)(5,7).
  - Stage 2: `oADDR` 0,1,2,3; `(A,B)` = (0,4)(1,5)(2,6)(3,7).
  - `oDONE` at cycle 13.
- Same run with `iREADY` low for cycles 5–7:
  - Outputs hold at stage 1, `b=0`.
  - Sequence resumes unchanged.
  - `oDONE` is delayed by 3 cycles.
- `iSTART` pulsed again at cycle 4 and during DONE: ignored; exactly one `oDONE`.
- `iRESET` at cycle 6: all outputs 0 next cycle, no `oDONE`; a new `iSTART` restarts cleanly at `s=0, b=0`.
- With the macro and GAP_CYC=4, P_BIT=3: `oVALID` drops for 4 cycles at each of the 2 boundaries; `oDONE` at cycle 21.
- Default P_BIT=7: 448 valid beats; `oTW_VALID` trails `oVALID` by exactly 1; max `oADDR` is 63 in the last stage.
